mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences each data-memory access of the Harvard CPU over an Avalon-style bus with waitrequest.
//  Stalls the pipeline until the access completes.
//  Generates the store byte lanes and byte enables.
//  Aligns, extends and merges load data, covering LB/LBU/LH/LHU/LW/LWL/LWR, and flags misaligned accesses.
// PARAMETERS
//  ADDR_W   32  byte-address width on both the datapath side and the bus side
//  TIMEOUT  0   cycles of waitrequest before addr_error is raised and the access aborts; 0 disables the timeout
// PORTS
//  clk             in   1   clock; every flop is on the rising edge
//  reset           in   1   asynchronous, active-high reset
//  mem_read        in   1   load request; held stable by the datapath while stall=1
//  mem_write       in   1   store request; held stable by the datapath while stall=1
//  ld_ctrl         in   3   000 LB, 001 LBU, 010 LH, 011 LHU, 101 LW, 110 LWL, 111 LWR
//  st_ctrl         in   2   00 SB, 01 SH, 10 SW
//  addr            in   32  byte address of the access
//  wdata           in   32  store data; low bits are right-justified
//  rt_old          in   32  current rt value; used for the LWL/LWR merge
//  stall           out  1   freezes the pipeline
//  load_data       out  32  aligned, extended and merged load result
//  load_valid      out  1   1-cycle pulse; load_data is valid while it is high
//  addr_error      out  1   1-cycle pulse: misalignment, illegal request, or timeout
//  avm_address     out  32  word-aligned bus address: {addr[31:2],2'b00}
//  avm_read        out  1   bus read strobe
//  avm_write       out  1   bus write strobe
//  avm_byteenable  out  4   active byte lanes
//  avm_writedata   out  32  lane-shifted store data
//  avm_readdata    in   32  bus read data
//  avm_waitrequest in   1   slave not ready; the bus outputs must be held unchanged
// BEHAVIOUR
//  - Reset, applied asynchronously: state=IDLE; every output is 0, including load_data and the avm_* signals.
//  - FSM state IDLE:
//     - stall = mem_read | mem_write, combinational.
//     - A legal request registers the bus outputs, then the FSM moves to ACCESS.
//     - An illegal request moves the FSM to ERR. There is no bus cycle.
//  - FSM state ACCESS: avm_read or avm_write is high and stall=1.
//     - The FSM remains in ACCESS while waitrequest=1.
//     - On the first edge with waitrequest=0, a load captures avm_readdata. The FSM then moves to DONE.
//  - FSM state DONE: lasts 1 cycle with stall=0 and avm_* strobes=0.
//     - For a load, load_valid=1. load_data holds its value until the next load.
//     - The next state is IDLE. A request seen during DONE is not accepted; it is serviced from IDLE on the following cycle.
//  - FSM state ERR: lasts 1 cycle with addr_error=1 and stall=0, then IDLE.
//     - The datapath drops the request on the addr_error pulse. No retry.
//  - Minimum latency: a request seen in cycle 0 gives load_valid in cycle 2, with zero wait states.
//  - Illegal requests:
//     - mem_read and mem_write both high.
//     - ld_ctrl=100.
//     - st_ctrl=11.
//     - LH/LHU/SH with addr[0]=1.
//     - LW/SW with addr[1:0]!=0.
//     - LB, LBU, SB, LWL and LWR are never misaligned.
//  - Timeout: when TIMEOUT>0 and waitrequest stays high for TIMEOUT cycles, the strobes drop and the FSM goes to ERR.
//  - Notation: o=addr[1:0], m=captured word; memory is little-endian with byte k at m[8k+7:8k].
//  - Loads:
//     - LB: load_data = sign-extended byte o. LBU: zero-extended byte o.
//     - LH: load_data = sign-extended m[16*o[1]+15 : 16*o[1]]. LHU: the same halfword, zero-extended.
//     - LW: load_data = m.
//     - LWL: load_data = (m << 8*(3-o)) | (rt_old & (32'h00FFFFFF >> 8*o)).
//     - LWR: load_data = (m >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
//  - Byte enables:
//     - Loads: LB/LBU 4'b0001<<o; LH/LHU 4'b0011<<o; LW/LWL/LWR 4'b1111.
//     - Stores: SB 4'b0001<<o; SH 4'b0011<<o; SW 4'b1111.
//  - Store data: avm_writedata = wdata << 8*o, using the byte/halfword of wdata selected by st_ctrl.
//  - rt_old is sampled in the DONE cycle. The datapath holds it stable through the access.
//  - Reset mid-access: the strobes drop immediately, with no completion pulse. The bus slave tolerates this abort.
// STRUCTURE
//  - Shared package mem_pkg: the ld_ctrl/st_ctrl encodings as localparams and the FSM state enum (IDLE, ACCESS, DONE, ERR).
//  - Sub-module load_align: purely combinational, (m, o, ld_ctrl, rt_old) -> load_data.
//     - It replaces the current load-extension logic.
//     - Its output is registered in DONE.
//  - The FSM, the legality check, lane generation and the timeout counter live in this module.
// TESTING
//  1. Timing, LW, zero wait states: addr=0x100, m=0xDEADBEEF.
//     - Expected: avm_read high in cycle 1; load_valid in cycle 2; load_data=0xDEADBEEF; stall high in cycles 0-1 only.
//  2. LB with 3 wait states: addr=0x103, m=0x80123456.
//     - Expected: byteenable=1000; stall high for 5 cycles; load_data=0xFFFFFF80.
//     - With LBU: load_data=0x00000080.
//  3. LWL/LWR: m=0x44332211, rt_old=0xAABBCCDD.
//     - LWL o=1: load_data=0x2211CCDD.
//     - LWR o=1: load_data=0xAA443322.
//  4. SH: addr=0x206, wdata=0x0000BEEF.
//     - Expected: byteenable=1100; avm_writedata[31:16]=0xBEEF; avm_address=0x204.
//  5. Errors:
//     - LW at addr=0x102: addr_error pulse, no avm strobe.
//     - mem_read and mem_write both high: addr_error pulse.
//     - TIMEOUT=4 with waitrequest stuck high: strobes drop, then addr_error.
//  6. Reset mid-access: reset asserted during ACCESS.
//     - Expected: avm_read=0 and stall=0 immediately (async), state=IDLE.
//     - After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: load/store control encodings, FSM states and the request
// decode helpers shared by the memory access controller and its aligner.
package mem_pkg;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LBU = 3'b001;
   localparam logic [2:0] LD_LH  = 3'b010;
   localparam logic [2:0] LD_LHU = 3'b011;
   localparam logic [2:0] LD_LW  = 3'b101;
   localparam logic [2:0] LD_LWL = 3'b110;
   localparam logic [2:0] LD_LWR = 3'b111;

   localparam logic [1:0] ST_SB  = 2'b00;
   localparam logic [1:0] ST_SH  = 2'b01;
   localparam logic [1:0] ST_SW  = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   // A request is legal when exactly one of read/write is asked for, the
   // encoding exists, and halfword/word accesses are naturally aligned.
   function automatic logic req_legal(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] ld,
                                      input logic [1:0] st,
                                      input logic [1:0] o);
      logic ok;
      ok = 1'b1;
      if (rd && wr) begin
         ok = 1'b0;
      end else if (rd) begin
         case (ld)
            LD_LB, LD_LBU, LD_LWL, LD_LWR: ok = 1'b1;
            LD_LH, LD_LHU:                 ok = ~o[0];
            LD_LW:                         ok = (o == 2'b00);
            default:                       ok = 1'b0;
         endcase
      end else if (wr) begin
         case (st)
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = ~o[0];
            ST_SW:   ok = (o == 2'b00);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Byte lanes touched by a load; LWL/LWR always fetch the whole word.
   function automatic logic [3:0] load_be(input logic [2:0] ld, input logic [1:0] o);
      logic [3:0] be;
      case (ld)
         LD_LB, LD_LBU: be = 4'b0001 << o;
         LD_LH, LD_LHU: be = 4'b0011 << o;
         default:       be = 4'b1111;
      endcase
      return be;
   endfunction

   // Byte lanes written by a store.
   function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] o);
      logic [3:0] be;
      case (st)
         ST_SB:   be = 4'b0001 << o;
         ST_SH:   be = 4'b0011 << o;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Right-justified store data moved onto the lanes selected by the offset.
   function automatic logic [31:0] store_data(input logic [1:0]  st,
                                              input logic [1:0]  o,
                                              input logic [31:0] wdata);
      logic [31:0] d;
      case (st)
         ST_SB:   d = {24'h0, wdata[7:0]}  << {o, 3'b000};
         ST_SH:   d = {16'h0, wdata[15:0]} << {o, 3'b000};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: Avalon-MM data bus with waitrequest between the
// access controller (master) and the data memory (slave).
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [3:0]        avm_byteenable;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;

   modport master (
      output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/load_align.sv
// load_align: turns the captured bus word into the architectural load
// result (byte/halfword select with sign or zero extension, LWL/LWR merge).
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] m,
   input  logic [1:0]  o,
   input  logic [2:0]  ld_ctrl,
   input  logic [31:0] rt_old,
   output logic [31:0] load_data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed byte/halfword and build the extended or merged result.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      load_data = 32'h0;
      byte_sel  = m[{o, 3'b000} +: 8];
      half_sel  = m[{o[1], 4'b0000} +: 16];
      case (ld_ctrl)
         LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  load_data = {24'h0, byte_sel};
         LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  load_data = {16'h0, half_sel};
         LD_LW:   load_data = m;
         // Shift by 8*(3-o); for a 2-bit offset 3-o is simply ~o.
         LD_LWL:  load_data = (m << {~o, 3'b000}) | (rt_old & (32'h00FF_FFFF >> {o, 3'b000}));
         LD_LWR:  load_data = (m >> {o, 3'b000}) | (rt_old & ~(32'hFFFF_FFFF >> {o, 3'b000}));
         default: load_data = 32'h0;
      endcase
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one data-memory access per request over the Avalon
// bus, stalls the pipeline until it completes, and reports bad requests.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        ld_ctrl,
   input  logic [1:0]        st_ctrl,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       rt_old,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              load_valid,
   output logic              addr_error,
   mem_access_ctrl_if.master avm
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state_q;
   state_t           state_d;
   logic             req;
   logic             legal;
   logic             accept;
   logic             complete;
   logic             timeout_hit;
   logic [1:0]       offset;
   logic             op_load_q;
   logic [2:0]       ld_ctrl_q;
   logic [1:0]       off_q;
   logic [31:0]      rdata_q;
   logic [31:0]      load_data_q;
   logic [31:0]      align_data;
   logic [CNT_W-1:0] wait_cnt_q;

   assign req      = mem_read | mem_write;
   assign offset   = addr[1:0];
   assign legal    = req_legal(mem_read, mem_write, ld_ctrl, st_ctrl, offset);
   assign accept   = (state_q == IDLE) && req && legal;
   assign complete = (state_q == ACCESS) && !avm.avm_waitrequest;
   // Fires on the TIMEOUT-th consecutive waitrequest cycle of an access.
   assign timeout_hit = (TIMEOUT > 0) && (state_q == ACCESS) && avm.avm_waitrequest
                        && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

   load_align u_load_align (
      .m         (rdata_q),
      .o         (off_q),
      .ld_ctrl   (ld_ctrl_q),
      .rt_old    (rt_old),
      .load_data (align_data)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: IDLE -> ACCESS/ERR, ACCESS waits out waitrequest, DONE/ERR last one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) state_d = legal ? ACCESS : ERR;
         end
         ACCESS: begin
            if (complete)         state_d = DONE;
            else if (timeout_hit) state_d = ERR;
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: stall, completion/error pulses and the visible load result.
   always_comb begin
      stall      = 1'b0;
      load_valid = 1'b0;
      addr_error = 1'b0;
      load_data  = load_data_q;
      // Reset gates the combinational stall so the pipeline is released at once,
      // even while the datapath still holds its request.
      if (!reset) begin
         case (state_q)
            IDLE:   stall = req;
            ACCESS: stall = 1'b1;
            DONE: begin
               if (op_load_q) begin
                  load_valid = 1'b1;
                  load_data  = align_data;
               end
            end
            ERR:     addr_error = 1'b1;
            default: stall = 1'b0;
         endcase
      end
   end

   // Bus outputs: loaded on accept, held through waitrequest, strobes dropped on completion or timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avm.avm_address    <= '0;
         avm.avm_read       <= 1'b0;
         avm.avm_write      <= 1'b0;
         avm.avm_byteenable <= 4'h0;
         avm.avm_writedata  <= 32'h0;
      end else if (accept) begin
         avm.avm_address    <= {addr[ADDR_W-1:2], 2'b00};
         avm.avm_read       <= mem_read;
         avm.avm_write      <= mem_write;
         avm.avm_byteenable <= mem_read ? load_be(ld_ctrl, offset) : store_be(st_ctrl, offset);
         avm.avm_writedata  <= mem_write ? store_data(st_ctrl, offset, wdata) : 32'h0;
      end else if (complete || timeout_hit) begin
         avm.avm_read       <= 1'b0;
         avm.avm_write      <= 1'b0;
      end
   end

   // Access context, read-data capture, held load result and waitrequest counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_load_q   <= 1'b0;
         ld_ctrl_q   <= 3'b000;
         off_q       <= 2'b00;
         rdata_q     <= 32'h0;
         load_data_q <= 32'h0;
         wait_cnt_q  <= '0;
      end else begin
         if (accept) begin
            op_load_q  <= mem_read;
            ld_ctrl_q  <= ld_ctrl;
            off_q      <= offset;
            wait_cnt_q <= '0;
         end else if (state_q == ACCESS && avm.avm_waitrequest && TIMEOUT > 0) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
         if (complete && op_load_q) rdata_q <= avm.avm_readdata;
         if (state_q == DONE && op_load_q) load_data_q <= align_data;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors against mem_access_ctrl with a
// wait-state bus slave model and a queue-based scoreboard monitor.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   typedef enum int {EV_BUS = 0, EV_LOAD = 1, EV_ERR = 2} ev_e;
   typedef struct {
      ev_e         kind;
      logic [31:0] a;
      logic [3:0]  be;
      logic        wr;
      logic [31:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  ld_ctrl = 3'b000;
   logic [1:0]  st_ctrl = 2'b00;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rt_old = 32'h0;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        addr_error;

   int          n_checks = 0;
   int          n_err = 0;
   ev_t         exp_q[$];
   int          ws = 0;
   int          wcnt = 0;
   logic [31:0] rd_word = 32'h0;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(32)) bus ();

   mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ld_ctrl    (ld_ctrl),
      .st_ctrl    (st_ctrl),
      .addr       (addr),
      .wdata      (wdata),
      .rt_old     (rt_old),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .addr_error (addr_error),
      .avm        (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic wr, input logic [31:0] d);
      exp_q.push_back('{kind: EV_BUS, a: a, be: be, wr: wr, d: d});
   endtask

   task automatic exp_load(input logic [31:0] d);
      exp_q.push_back('{kind: EV_LOAD, a: 32'h0, be: 4'h0, wr: 1'b0, d: d});
   endtask

   task automatic exp_err();
      exp_q.push_back('{kind: EV_ERR, a: 32'h0, be: 4'h0, wr: 1'b0, d: 32'h0});
   endtask

   // Scoreboard: pop the oldest expected event and compare it with what the DUT shows.
   task automatic score(input ev_e k);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL unexpected_event: got event kind %0d, expected none", k);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == k) begin
         case (k)
            EV_BUS: begin
               check("bus_address", bus.avm_address, e.a);
               check("bus_byteenable", {28'h0, bus.avm_byteenable}, {28'h0, e.be});
               check("bus_write", {31'h0, bus.avm_write}, {31'h0, e.wr});
               check("bus_read", {31'h0, bus.avm_read}, {31'h0, ~e.wr});
               if (e.wr) check("bus_writedata", bus.avm_writedata, e.d);
            end
            EV_LOAD: check("load_data", load_data, e.d);
            default: begin
               check("err_stall", {31'h0, stall}, 32'h0);
               check("err_no_strobe", {31'h0, bus.avm_read | bus.avm_write}, 32'h0);
            end
         endcase
      end
   endtask

   // Monitor: every bus handshake, load_valid and addr_error pulse is scored.
   always @(negedge clk) begin
      if (!reset) begin
         if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) score(EV_BUS);
         if (load_valid) score(EV_LOAD);
         if (addr_error) score(EV_ERR);
      end
   end

   // Bus slave: holds waitrequest for ws cycles of each strobe, then returns rd_word.
   initial begin
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.avm_read || bus.avm_write) begin
            if (wcnt < ws) begin
               bus.avm_waitrequest = 1'b1;
               wcnt++;
            end else begin
               bus.avm_waitrequest = 1'b0;
               bus.avm_readdata    = rd_word;
            end
         end else begin
            wcnt = 0;
            bus.avm_waitrequest = 1'b0;
         end
      end
   end

   // Issue one request (caller is just after a rising edge) and hold it until stall drops.
   task automatic issue(input logic rd, input logic wr, input logic [2:0] ld, input logic [1:0] st,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rt,
                        input logic [31:0] word, input int n_ws,
                        output int stall_cyc, output int strobe_cyc,
                        output logic lv, output logic ae, output logic strobe_end);
      int c;
      rd_word    = word;
      ws         = n_ws;
      mem_read   = rd;
      mem_write  = wr;
      ld_ctrl    = ld;
      st_ctrl    = st;
      addr       = a;
      wdata      = wd;
      rt_old     = rt;
      strobe_cyc = -1;
      c          = 0;
      forever begin
         @(negedge clk);
         if ((bus.avm_read || bus.avm_write) && strobe_cyc < 0) strobe_cyc = c;
         if (!stall) break;
         c++;
         if (c > 40) begin
            n_checks++;
            n_err++;
            $display("FAIL stall_timeout: stall still high after %0d cycles, expected release", c);
            break;
         end
      end
      stall_cyc  = c;
      lv         = load_valid;
      ae         = addr_error;
      strobe_end = bus.avm_read | bus.avm_write;
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   sc;
      int   stb;
      logic lv;
      logic ae;
      logic se;

      // Reset state: every output is zero.
      #12;
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_load_valid", {31'h0, load_valid}, 32'h0);
      check("rst_addr_error", {31'h0, addr_error}, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_avm_read", {31'h0, bus.avm_read}, 32'h0);
      check("rst_avm_write", {31'h0, bus.avm_write}, 32'h0);
      check("rst_avm_address", bus.avm_address, 32'h0);
      check("rst_avm_byteenable", {28'h0, bus.avm_byteenable}, 32'h0);
      check("rst_avm_writedata", bus.avm_writedata, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // LW, zero wait states: strobe in cycle 1, load_valid in cycle 2.
      exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
      exp_load(32'hDEAD_BEEF);
      issue(1'b1, 1'b0, LD_LW, ST_SB, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, sc, stb, lv, ae, se);
      check("lw_stall_cycles", sc, 2);
      check("lw_strobe_cycle", stb, 1);
      check("lw_load_valid_cycle2", {31'h0, lv}, 32'h1);
      check("lw_strobe_dropped", {31'h0, se}, 32'h0);

      // LB / LBU at offset 3 with three wait states.
      exp_bus(32'h100, 4'b1000, 1'b0, 32'h0);
      exp_load(32'hFFFF_FF80);
      issue(1'b1, 1'b0, LD_LB, ST_SB, 32'h103, 32'h0, 32'h0, 32'h8012_3456, 3, sc, stb, lv, ae, se);
      check("lb_stall_cycles", sc, 5);
      check("lb_load_valid", {31'h0, lv}, 32'h1);
      exp_bus(32'h100, 4'b1000, 1'b0, 32'h0);
      exp_load(32'h0000_0080);
      issue(1'b1, 1'b0, LD_LBU, ST_SB, 32'h103, 32'h0, 32'h0, 32'h8012_3456, 3, sc, stb, lv, ae, se);
      check("lbu_stall_cycles", sc, 5);

      // LWL / LWR merge at offset 1.
      exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
      exp_load(32'h2211_CCDD);
      issue(1'b1, 1'b0, LD_LWL, ST_SB, 32'h101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, sc, stb, lv, ae, se);
      exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
      exp_load(32'hAA44_3322);
      issue(1'b1, 1'b0, LD_LWR, ST_SB, 32'h101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 1, sc, stb, lv, ae, se);
      check("lwr_stall_cycles", sc, 3);

      // LH upper half (sign-extended), LHU lower half.
      exp_bus(32'h100, 4'b1100, 1'b0, 32'h0);
      exp_load(32'hFFFF_8012);
      issue(1'b1, 1'b0, LD_LH, ST_SB, 32'h102, 32'h0, 32'h0, 32'h8012_3456, 0, sc, stb, lv, ae, se);
      exp_bus(32'h100, 4'b0011, 1'b0, 32'h0);
      exp_load(32'h0000_3456);
      issue(1'b1, 1'b0, LD_LHU, ST_SB, 32'h100, 32'h0, 32'h0, 32'h8012_3456, 0, sc, stb, lv, ae, se);

      // Stores: lanes and shifted data; load_data must hold the last load.
      exp_bus(32'h204, 4'b1100, 1'b1, 32'hBEEF_0000);
      issue(1'b0, 1'b1, LD_LB, ST_SH, 32'h206, 32'h0000_BEEF, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);
      check("sh_stall_cycles", sc, 2);
      check("sh_no_load_valid", {31'h0, lv}, 32'h0);
      check("sh_load_data_held", load_data, 32'h0000_3456);
      exp_bus(32'h300, 4'b0010, 1'b1, 32'h0000_7800);
      issue(1'b0, 1'b1, LD_LB, ST_SB, 32'h301, 32'h1234_5678, 32'h0, 32'h0, 2, sc, stb, lv, ae, se);
      exp_bus(32'h300, 4'b1111, 1'b1, 32'hCAFE_F00D);
      issue(1'b0, 1'b1, LD_LB, ST_SW, 32'h300, 32'hCAFE_F00D, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);

      // Illegal requests: one stall cycle, then an error pulse with no bus cycle.
      exp_err();
      issue(1'b1, 1'b0, LD_LW, ST_SB, 32'h102, 32'h0, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);
      check("lw_mis_stall_cycles", sc, 1);
      check("lw_mis_addr_error", {31'h0, ae}, 32'h1);
      check("lw_mis_no_strobe", stb, -1);
      exp_err();
      issue(1'b1, 1'b1, LD_LW, ST_SW, 32'h100, 32'h0, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);
      check("rw_both_addr_error", {31'h0, ae}, 32'h1);
      exp_err();
      issue(1'b0, 1'b1, LD_LB, ST_SH, 32'h203, 32'h0, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);
      check("sh_mis_no_strobe", stb, -1);
      exp_err();
      issue(1'b1, 1'b0, 3'b100, ST_SB, 32'h100, 32'h0, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);
      exp_err();
      issue(1'b0, 1'b1, LD_LB, 2'b11, 32'h100, 32'h0, 32'h0, 32'h0, 0, sc, stb, lv, ae, se);

      // Timeout: waitrequest stuck high for four cycles aborts the access.
      exp_err();
      issue(1'b1, 1'b0, LD_LW, ST_SB, 32'h400, 32'h0, 32'h0, 32'h0, 1000, sc, stb, lv, ae, se);
      check("timeout_stall_cycles", sc, 5);
      check("timeout_strobe_cycle", stb, 1);
      check("timeout_addr_error", {31'h0, ae}, 32'h1);
      check("timeout_strobe_dropped", {31'h0, se}, 32'h0);

      // Reset in the middle of an access: outputs drop at once, no completion.
      rd_word   = 32'h1111_2222;
      ws        = 3;
      mem_read  = 1'b1;
      ld_ctrl   = LD_LW;
      addr      = 32'h500;
      @(negedge clk);
      @(negedge clk);
      check("midrst_pre_strobe", {31'h0, bus.avm_read}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_avm_read", {31'h0, bus.avm_read}, 32'h0);
      check("midrst_stall", {31'h0, stall}, 32'h0);
      check("midrst_load_valid", {31'h0, load_valid}, 32'h0);
      check("midrst_load_data", load_data, 32'h0);
      mem_read = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      exp_bus(32'h504, 4'b1111, 1'b0, 32'h0);
      exp_load(32'h0BAD_F00D);
      issue(1'b1, 1'b0, LD_LW, ST_SB, 32'h504, 32'h0, 32'h0, 32'h0BAD_F00D, 0, sc, stb, lv, ae, se);
      check("postrst_stall_cycles", sc, 2);
      check("postrst_load_valid", {31'h0, lv}, 32'h1);

      @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
